// File: rtl/traffic_pkg.sv
// Shared lamp codes, direction and scheduler-state types for the traffic phase scheduler.
package traffic_pkg;

    localparam logic [2:0] LIGHT_GREEN  = 3'b001;
    localparam logic [2:0] LIGHT_YELLOW = 3'b010;
    localparam logic [2:0] LIGHT_RED    = 3'b100;

    typedef enum logic [1:0] {
        DIR_N = 2'd0,
        DIR_S = 2'd1,
        DIR_E = 2'd2,
        DIR_W = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GREEN  = 2'd1,
        ST_YELLOW = 2'd2,
        ST_ALLRED = 2'd3
    } sched_state_t;

endpackage

// File: rtl/traffic_rr_pick.sv
// Combinational 4-way round-robin picker: first set request bit after 'last', wrapping,
// with 'last' itself considered only at lowest priority.
module traffic_rr_pick (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       valid
);

    // Scan from farthest to nearest so the nearest requester after 'last' wins.
    always_comb begin
        pick  = last;
        valid = 1'b0;
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) begin
                pick  = last + 2'(i);
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// Demand-actuated four-way phase scheduler with min/max green, yellow and, when
// TRAFFIC_ALL_RED_EN is defined, an all-red clearance between phases.
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int MIN_GREEN = 4,
    parameter int MAX_GREEN = 15,
    parameter int YELLOW    = 3,
    parameter int ALL_RED   = 2,
    parameter int CNT_W     = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [3:0] req,
    output logic [2:0] north_light,
    output logic [2:0] south_light,
    output logic [2:0] east_light,
    output logic [2:0] west_light,
    output logic [1:0] gnt,
    output logic       gnt_valid
);

    localparam logic [CNT_W-1:0] MIN_LAST = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST = CNT_W'(MAX_GREEN - 1);
    localparam logic [CNT_W-1:0] Y_LAST   = CNT_W'(YELLOW - 1);
    localparam logic [CNT_W-1:0] AR_LAST  = CNT_W'(ALL_RED - 1);

    sched_state_t     state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [3:0]       pend, pend_n;
    logic [1:0]       last, last_n;
    logic [1:0]       gnt_n;
    logic [3:0]       cand, gmask, other;
    logic [1:0]       pick;
    logic             pick_valid;
    logic             go_green;

    function automatic logic timed_done(input sched_state_t s, input logic [CNT_W-1:0] c);
        return c == ((s == ST_ALLRED) ? AR_LAST : Y_LAST);
    endfunction

    function automatic logic [2:0] lamp(input sched_state_t s, input logic [1:0] g, input dir_t d);
        if (g != d) return LIGHT_RED;
        case (s)
            ST_GREEN:  return LIGHT_GREEN;
            ST_YELLOW: return LIGHT_YELLOW;
            default:   return LIGHT_RED;
        endcase
    endfunction

    assign cand  = pend | req;
    assign gmask = 4'b0001 << gnt;
    assign other = cand & ~gmask;

    traffic_rr_pick u_pick (
        .req   (cand),
        .last  (last),
        .pick  (pick),
        .valid (pick_valid)
    );

    always_comb begin
        state_n  = state;
        gnt_n    = gnt;
        last_n   = last;
        go_green = 1'b0;
        // The green direction's own detector is not latched while it is being served.
        pend_n   = pend | (req & ~((state == ST_GREEN) ? gmask : 4'b0000));

        case (state)
            ST_IDLE: begin
                if (pick_valid) go_green = 1'b1;
            end
            ST_GREEN: begin
                if (cnt >= MIN_LAST && other != 4'b0000 && (!req[gnt] || cnt >= MAX_LAST))
                    state_n = ST_YELLOW;
            end
            ST_YELLOW: begin
                if (timed_done(state, cnt)) begin
`ifdef TRAFFIC_ALL_RED_EN
                    state_n = ST_ALLRED;
`else
                    if (pick_valid) go_green = 1'b1;
                    else            state_n  = ST_IDLE;
`endif
                end
            end
`ifdef TRAFFIC_ALL_RED_EN
            ST_ALLRED: begin
                if (timed_done(state, cnt)) begin
                    if (pick_valid) go_green = 1'b1;
                    else            state_n  = ST_IDLE;
                end
            end
`endif
            default: state_n = ST_IDLE;
        endcase

        if (go_green) begin
            state_n      = ST_GREEN;
            gnt_n        = pick;
            last_n       = pick;
            pend_n[pick] = 1'b0;
        end

        if (state_n != state)   cnt_n = '0;
        else if (cnt < MAX_LAST) cnt_n = cnt + CNT_W'(1);
        else                     cnt_n = cnt;
    end

    // Outputs are decoded from the next state so lamps change on the same edge as the state.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            pend        <= 4'b0000;
            last        <= DIR_W;
            gnt         <= DIR_N;
            gnt_valid   <= 1'b0;
            north_light <= LIGHT_RED;
            south_light <= LIGHT_RED;
            east_light  <= LIGHT_RED;
            west_light  <= LIGHT_RED;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            pend        <= pend_n;
            last        <= last_n;
            gnt         <= gnt_n;
            gnt_valid   <= (state_n == ST_GREEN);
            north_light <= lamp(state_n, gnt_n, DIR_N);
            south_light <= lamp(state_n, gnt_n, DIR_S);
            east_light  <= lamp(state_n, gnt_n, DIR_E);
            west_light  <= lamp(state_n, gnt_n, DIR_W);
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed self-checking bench for traffic_phase_scheduler (default parameters,
// with or without TRAFFIC_ALL_RED_EN).
module tb_traffic_phase_scheduler;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] req     = 4'b0000;
    logic [2:0] north_light, south_light, east_light, west_light;
    logic [1:0] gnt;
    logic       gnt_valid;
    logic [11:0] lamps;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int MODE_RED    = 0;
    localparam int MODE_GREEN  = 1;
    localparam int MODE_YELLOW = 2;

    traffic_phase_scheduler dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (req),
        .north_light (north_light),
        .south_light (south_light),
        .east_light  (east_light),
        .west_light  (west_light),
        .gnt         (gnt),
        .gnt_valid   (gnt_valid)
    );

    always #5 clock = ~clock;

    assign lamps = {west_light, east_light, south_light, north_light};

    function automatic logic [11:0] exp_lamps(input int mode, input int d);
        logic [11:0] r;
        r = 12'b100_100_100_100;
        if (mode == MODE_GREEN)       r[d*3 +: 3] = 3'b001;
        else if (mode == MODE_YELLOW) r[d*3 +: 3] = 3'b010;
        return r;
    endfunction

    function automatic int nonred(input logic [11:0] l);
        int n;
        n = 0;
        for (int i = 0; i < 4; i++) if (l[i*3 +: 3] != 3'b100) n++;
        return n;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        req     = 4'b0000;
        tick();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        req     = 4'b0001;
        tick();
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_RED, 0)) begin
            n_fail++;
            $display("FAIL reset_lamps: got %b want %b", lamps, exp_lamps(MODE_RED, 0));
        end
        n_checks++;
        if (gnt !== 2'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_gnt: got gnt=%0d valid=%b want gnt=0 valid=0", gnt, gnt_valid);
        end
        reset_n = 1'b1;
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_GREEN, 0) || gnt !== 2'd0 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_green: got lamps=%b gnt=%0d valid=%b want lamps=%b gnt=0 valid=1",
                     lamps, gnt, gnt_valid, exp_lamps(MODE_GREEN, 0));
        end
    endtask

    task automatic test_rest_in_green();
        for (int c = 0; c < 40; c++) begin
            tick();
            n_checks++;
            if (lamps !== exp_lamps(MODE_GREEN, 0) || gnt_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL rest_green c%0d: got lamps=%b valid=%b want lamps=%b valid=1",
                         c, lamps, gnt_valid, exp_lamps(MODE_GREEN, 0));
            end
        end
    endtask

    task automatic test_max_out();
        do_reset();
        req = 4'b0001;
        tick();
        for (int c = 0; c < 15; c++) begin
            n_checks++;
            if (lamps !== exp_lamps(MODE_GREEN, 0) || gnt !== 2'd0) begin
                n_fail++;
                $display("FAIL max_green c%0d: got lamps=%b gnt=%0d want lamps=%b gnt=0",
                         c, lamps, gnt, exp_lamps(MODE_GREEN, 0));
            end
            req = (c == 1) ? 4'b0101 : 4'b0001;
            tick();
        end
        for (int y = 0; y < 3; y++) begin
            n_checks++;
            if (lamps !== exp_lamps(MODE_YELLOW, 0) || gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL max_yellow y%0d: got lamps=%b valid=%b want lamps=%b valid=0",
                         y, lamps, gnt_valid, exp_lamps(MODE_YELLOW, 0));
            end
            tick();
        end
`ifdef TRAFFIC_ALL_RED_EN
        for (int a = 0; a < 2; a++) begin
            n_checks++;
            if (lamps !== exp_lamps(MODE_RED, 0) || gnt_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL max_allred a%0d: got lamps=%b valid=%b want lamps=%b valid=0",
                         a, lamps, gnt_valid, exp_lamps(MODE_RED, 0));
            end
            tick();
        end
`endif
        n_checks++;
        if (lamps !== exp_lamps(MODE_GREEN, 2) || gnt !== 2'd2 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL max_next_east: got lamps=%b gnt=%0d valid=%b want lamps=%b gnt=2 valid=1",
                     lamps, gnt, gnt_valid, exp_lamps(MODE_GREEN, 2));
        end
    endtask

    task automatic test_gap_out();
        do_reset();
        req = 4'b0011;
        tick();
        for (int c = 0; c < 4; c++) begin
            n_checks++;
            if (lamps !== exp_lamps(MODE_GREEN, 0)) begin
                n_fail++;
                $display("FAIL gap_green c%0d: got %b want %b", c, lamps, exp_lamps(MODE_GREEN, 0));
            end
            if (c == 1) req = 4'b0010;
            tick();
        end
        n_checks++;
        if (lamps !== exp_lamps(MODE_YELLOW, 0)) begin
            n_fail++;
            $display("FAIL gap_yellow: got %b want %b", lamps, exp_lamps(MODE_YELLOW, 0));
        end
        tick();
        tick();
        tick();
`ifdef TRAFFIC_ALL_RED_EN
        tick();
        tick();
`endif
        n_checks++;
        if (lamps !== exp_lamps(MODE_GREEN, 1) || gnt !== 2'd1) begin
            n_fail++;
            $display("FAIL gap_next_south: got lamps=%b gnt=%0d want lamps=%b gnt=1",
                     lamps, gnt, exp_lamps(MODE_GREEN, 1));
        end
    endtask

    task automatic test_round_robin();
        int order [5];
        order = '{0, 1, 2, 3, 0};
        reset_n = 1'b0;
        req     = 4'b1111;
        tick();
        reset_n = 1'b1;
        tick();
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 15; c++) begin
                n_checks++;
                if (lamps !== exp_lamps(MODE_GREEN, order[p]) || gnt !== 2'(order[p])) begin
                    n_fail++;
                    $display("FAIL rr_green p%0d c%0d: got lamps=%b gnt=%0d want lamps=%b gnt=%0d",
                             p, c, lamps, gnt, exp_lamps(MODE_GREEN, order[p]), order[p]);
                end
                n_checks++;
                if (nonred(lamps) > 1) begin
                    n_fail++;
                    $display("FAIL rr_one_nonred: got %0d non-red lamps want at most 1", nonred(lamps));
                end
                tick();
            end
            if (p < 4) begin
                for (int y = 0; y < 3; y++) begin
                    n_checks++;
                    if (lamps !== exp_lamps(MODE_YELLOW, order[p])) begin
                        n_fail++;
                        $display("FAIL rr_yellow p%0d y%0d: got %b want %b",
                                 p, y, lamps, exp_lamps(MODE_YELLOW, order[p]));
                    end
                    tick();
                end
`ifdef TRAFFIC_ALL_RED_EN
                for (int a = 0; a < 2; a++) begin
                    n_checks++;
                    if (lamps !== exp_lamps(MODE_RED, 0)) begin
                        n_fail++;
                        $display("FAIL rr_allred p%0d a%0d: got %b want %b",
                                 p, a, lamps, exp_lamps(MODE_RED, 0));
                    end
                    tick();
                end
`endif
            end
        end
    endtask

    task automatic test_reset_mid_phase();
        do_reset();
        req = 4'b0010;
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_GREEN, 1) || gnt !== 2'd1) begin
            n_fail++;
            $display("FAIL mid_south_green: got lamps=%b gnt=%0d want lamps=%b gnt=1",
                     lamps, gnt, exp_lamps(MODE_GREEN, 1));
        end
        req = 4'b0100;
        tick();
        tick();
        tick();
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_YELLOW, 1)) begin
            n_fail++;
            $display("FAIL mid_south_yellow: got %b want %b", lamps, exp_lamps(MODE_YELLOW, 1));
        end
        reset_n = 1'b0;
        req     = 4'b0000;
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_RED, 0) || gnt !== 2'd0 || gnt_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_reset: got lamps=%b gnt=%0d valid=%b want lamps=%b gnt=0 valid=0",
                     lamps, gnt, gnt_valid, exp_lamps(MODE_RED, 0));
        end
        reset_n = 1'b1;
        req     = 4'b1000;
        tick();
        n_checks++;
        if (lamps !== exp_lamps(MODE_GREEN, 3) || gnt !== 2'd3 || gnt_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_west_after_reset: got lamps=%b gnt=%0d valid=%b want lamps=%b gnt=3 valid=1",
                     lamps, gnt, gnt_valid, exp_lamps(MODE_GREEN, 3));
        end
    endtask

    initial begin
        test_reset();
        test_rest_in_green();
        test_max_out();
        test_gap_out();
        test_round_robin();
        test_reset_mid_phase();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before summary");
        $fatal(1);
    end

endmodule
